bn_channel_scheduler: RTL and testbench
=======================================

// Module: bn_channel_scheduler
// PURPOSE
//  Sequences the BatchNorm+ReLU datapath one channel at a time for a full feature map.
//  Per channel: fetches gamma/beta/mean/variance from a parameter ROM, holds them stable,
//  streams IMG_HEIGHT*IMG_WIDTH features into the datapath, drains it, then advances.
//  Sits between the conv output FIFO / parameter ROM and the batchnorm_relu instance.
// PARAMETERS
//  IMG_HEIGHT  256  feature-map rows
//  IMG_WIDTH   256  feature-map columns
//  CHANNELS    64   channels per layer; PIX = IMG_HEIGHT*IMG_WIDTH features per channel
//  DATA_WIDTH  16   feature/parameter word width
//  AW          $clog2(CHANNELS*4)  ROM address width (derived localparam)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous, active-high reset
//  start        in   1    pulse: begin a layer (ignored unless IDLE)
//  abort        in   1    pulse: cancel layer, return to IDLE
//  busy         out  1    high from start accept until DONE/abort
//  done         out  1    one-cycle pulse after last channel drained
//  err          out  1    sticky: unexpected datapath output; cleared by start/rst
//  ch_idx       out  $clog2(CHANNELS)  channel currently scheduled
//  rom_en       out  1    ROM read strobe; data returns next cycle
//  rom_addr     out  AW   {ch_idx, k}, k: 0=gamma 1=beta 2=mean 3=variance
//  rom_data     in   DW   ROM read data (1-cycle latency)
//  gamma,beta,mean,variance  out  DW each  registered params to datapath
//  in_valid     in   1    upstream feature valid
//  in_ready     out  1    upstream ready; transfer when in_valid&in_ready
//  in_data      in   DW   upstream feature
//  dp_start     out  1    one-cycle pulse to datapath at layer start
//  dp_feature   out  DW   registered copy of in_data
//  dp_valid     out  1    registered transfer strobe
//  dp_valid_out in   1    datapath output strobe (used to count drain)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0; param registers 0.
//  FSM IDLE->LOAD->STREAM->DRAIN->(LOAD | FIN)->IDLE; abort from any non-IDLE -> IDLE next cycle.
//  IDLE: start -> ch_idx=0, err=0, busy=1, dp_start pulse, go LOAD.
//  LOAD: rom_en high 4 consecutive cycles, k=0..3; word k latched into its param register
//    cycle after its read; 5 cycles total, then STREAM. Params change only in LOAD.
//  STREAM: in_ready=1; each transfer -> dp_feature/dp_valid next cycle, in_cnt++.
//    Transfer with in_cnt==PIX-1 drops in_ready same-cycle combinationally -> DRAIN.
//    in_ready is 0 in every other state; no features lost or duplicated.
//  DRAIN: wait until out_cnt==PIX (dp_valid_out counted in STREAM and DRAIN);
//    then ch_idx==CHANNELS-1 ? FIN : ch_idx++, counters clear, LOAD.
//  FIN: done=1 one cycle, busy=0 next, IDLE. Throughput: PIX+5+drain cycles per channel.
//  err set: dp_valid_out in IDLE/LOAD, or when out_cnt already PIX; extra strobe not counted.
//  start while busy: ignored. abort same cycle as start in IDLE: abort wins, stay IDLE.
//  abort/rst mid-layer: params retained only until next LOAD (rst clears them), no done.
//  Counters in_cnt/out_cnt width $clog2(PIX+1); no wrap possible by construction.
// STRUCTURE
//  Shared package bn_pkg: state encoding, PARAM_GAMMA..PARAM_VAR index constants, PIX calc.
//  Single module; param loader (rom_en/addr/latch) is a natural sub-module bn_param_loader.
// TESTING
//  Reset: rst held 3 cycles mid-STREAM -> all outputs 0, in_ready 0, state IDLE.
//  2x2x2 map, ROM word=addr+1, in_valid always 1, datapath latency 4 -> ch0 params
//    1,2,3,4 then ch1 5,6,7,8; exactly 4 dp_valid per channel; done pulse once.
//  Backpressure: in_valid toggles 1/0 -> dp_feature sequence equals input order, no gaps lost.
//  Abort in ch1 DRAIN -> IDLE next cycle, busy 0, no done; new start reruns from ch0.
//  Spurious dp_valid_out during LOAD -> err=1 sticky until next start.
//  start pulsed during STREAM -> ignored, ch_idx and counts unchanged.

Source files
------------

// File: rtl/bn_pkg.sv
// Shared definitions for the BatchNorm+ReLU channel scheduler: the FSM state
// encoding, the parameter-word index within a channel's ROM block, and
// feature-map size helpers.
package bn_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FIN    = 3'd4
  } bn_state_e;

  // Word offsets inside the 4-word parameter block of one channel
  localparam logic [1:0] PARAM_GAMMA = 2'd0;
  localparam logic [1:0] PARAM_BETA  = 2'd1;
  localparam logic [1:0] PARAM_MEAN  = 2'd2;
  localparam logic [1:0] PARAM_VAR   = 2'd3;

  // Features per channel
  function automatic int calc_pix(input int height, input int width);
    return height * width;
  endfunction

  // Counter width able to hold 0..pix without wrapping
  function automatic int cnt_width(input int pix);
    return $clog2(pix + 1);
  endfunction

endpackage

// File: rtl/bn_param_loader.sv
// Parameter loader: on go_i it issues four back-to-back ROM reads for one
// channel (gamma, beta, mean, variance) and latches each returned word into
// its register one cycle after the read. done_o marks the cycle in which the
// last word (variance) is being latched. Registers hold between loads.
module bn_param_loader
  import bn_pkg::*;
#(
  parameter int CHW        = 6,
  parameter int DATA_WIDTH = 16,
  parameter int AW         = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  go_i,
  input  logic                  clr_i,
  input  logic [CHW-1:0]        ch_i,
  output logic                  rom_en_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic [DATA_WIDTH-1:0] mean_o,
  output logic [DATA_WIDTH-1:0] variance_o,
  output logic                  done_o
);

  logic                  rom_en_q, rom_en_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  lat_en_q, lat_en_d;
  logic [1:0]            lat_k_q, lat_k_d;
  logic [DATA_WIDTH-1:0] gamma_q, gamma_d;
  logic [DATA_WIDTH-1:0] beta_q, beta_d;
  logic [DATA_WIDTH-1:0] mean_q, mean_d;
  logic [DATA_WIDTH-1:0] var_q, var_d;

  // Read sequencing and one-cycle-late capture of the returned words
  always_comb begin
    rom_en_d = rom_en_q;
    addr_d   = addr_q;
    lat_en_d = 1'b0;
    lat_k_d  = lat_k_q;
    gamma_d  = gamma_q;
    beta_d   = beta_q;
    mean_d   = mean_q;
    var_d    = var_q;
    if (clr_i) begin
      // Cancelled load: stop reading, keep whatever parameters were held
      rom_en_d = 1'b0;
      lat_en_d = 1'b0;
    end else begin
      lat_en_d = rom_en_q;
      lat_k_d  = addr_q[1:0];
      if (go_i) begin
        rom_en_d = 1'b1;
        addr_d   = {ch_i, PARAM_GAMMA};
      end else if (rom_en_q) begin
        if (addr_q[1:0] == PARAM_VAR) begin
          rom_en_d = 1'b0;
        end else begin
          addr_d = addr_q + AW'(1'b1);
        end
      end else begin
        rom_en_d = 1'b0;
      end
      if (lat_en_q) begin
        case (lat_k_q)
          PARAM_GAMMA: gamma_d = rom_data_i;
          PARAM_BETA:  beta_d  = rom_data_i;
          PARAM_MEAN:  mean_d  = rom_data_i;
          PARAM_VAR:   var_d   = rom_data_i;
          default:     gamma_d = gamma_q;
        endcase
      end else begin
        gamma_d = gamma_q;
      end
    end
  end

  // Loader state and parameter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom_en_q <= 1'b0;
      addr_q   <= {AW{1'b0}};
      lat_en_q <= 1'b0;
      lat_k_q  <= 2'd0;
      gamma_q  <= {DATA_WIDTH{1'b0}};
      beta_q   <= {DATA_WIDTH{1'b0}};
      mean_q   <= {DATA_WIDTH{1'b0}};
      var_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      rom_en_q <= rom_en_d;
      addr_q   <= addr_d;
      lat_en_q <= lat_en_d;
      lat_k_q  <= lat_k_d;
      gamma_q  <= gamma_d;
      beta_q   <= beta_d;
      mean_q   <= mean_d;
      var_q    <= var_d;
    end
  end

  assign rom_en_o   = rom_en_q;
  assign rom_addr_o = addr_q;
  assign gamma_o    = gamma_q;
  assign beta_o     = beta_q;
  assign mean_o     = mean_q;
  assign variance_o = var_q;
  assign done_o     = lat_en_q && (lat_k_q == PARAM_VAR);

endmodule

// File: rtl/bn_channel_scheduler.sv
// Channel scheduler for the BatchNorm+ReLU datapath. For each channel it loads
// the four parameters, streams PIX features from upstream into the datapath,
// waits until PIX datapath outputs have been seen, then moves to the next
// channel. in_ready is intentionally combinational so that the last feature
// of a channel closes the input in the same cycle it is accepted.
// CHANNELS must be at least 2 so the channel index has a nonzero width.
module bn_channel_scheduler
  import bn_pkg::*;
#(
  parameter int IMG_HEIGHT = 256,
  parameter int IMG_WIDTH  = 256,
  parameter int CHANNELS   = 64,
  parameter int DATA_WIDTH = 16,
  localparam int CHW = $clog2(CHANNELS),
  localparam int AW  = $clog2(CHANNELS * 4)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [CHW-1:0]        ch_idx_o,
  output logic                  rom_en_o,
  output logic [AW-1:0]         rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] gamma_o,
  output logic [DATA_WIDTH-1:0] beta_o,
  output logic [DATA_WIDTH-1:0] mean_o,
  output logic [DATA_WIDTH-1:0] variance_o,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  dp_start_o,
  output logic [DATA_WIDTH-1:0] dp_feature_o,
  output logic                  dp_valid_o,
  input  logic                  dp_valid_out_i
);

  localparam int PIX = calc_pix(IMG_HEIGHT, IMG_WIDTH);
  localparam int CW  = cnt_width(PIX);
  localparam logic [CW-1:0]  PIX_FULL = CW'(PIX);
  localparam logic [CW-1:0]  PIX_LAST = CW'(PIX - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(CHANNELS - 1);

  bn_state_e             state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d, load_ch_s;
  logic [CW-1:0]         in_cnt_q, in_cnt_d;
  logic [CW-1:0]         out_cnt_q, out_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  dp_start_q, dp_start_d;
  logic [DATA_WIDTH-1:0] dp_feature_q, dp_feature_d;
  logic                  dp_valid_q, dp_valid_d;
  logic                  load_go_s, load_done_s, abort_s, in_ready_s, xfer_s;

  assign abort_s    = abort_i && (state_q != S_IDLE);
  assign in_ready_s = (state_q == S_STREAM) && !abort_i;
  assign xfer_s     = in_valid_i && in_ready_s;

  bn_param_loader #(
    .CHW       (CHW),
    .DATA_WIDTH(DATA_WIDTH),
    .AW        (AW)
  ) u_loader (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .go_i      (load_go_s),
    .clr_i     (abort_s),
    .ch_i      (load_ch_s),
    .rom_en_o  (rom_en_o),
    .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i),
    .gamma_o   (gamma_o),
    .beta_o    (beta_o),
    .mean_o    (mean_o),
    .variance_o(variance_o),
    .done_o    (load_done_s)
  );

  // Next-state logic: channel sequencing, feature/output accounting, error flag
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    dp_start_d = 1'b0;
    load_go_s  = 1'b0;
    load_ch_s  = ch_q;
    dp_valid_d = xfer_s;
    if (xfer_s) begin
      dp_feature_d = in_data_i;
    end else begin
      dp_feature_d = dp_feature_q;
    end

    // Datapath outputs count only while a channel is in flight and not yet full;
    // anything else is unexpected and flagged without being counted
    if (dp_valid_out_i) begin
      if ((state_q == S_STREAM || state_q == S_DRAIN) && (out_cnt_q != PIX_FULL)) begin
        out_cnt_d = out_cnt_q + CW'(1'b1);
      end else begin
        err_d = 1'b1;
      end
    end else begin
      out_cnt_d = out_cnt_q;
    end

    if (abort_s) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      in_cnt_d  = {CW{1'b0}};
      out_cnt_d = {CW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !abort_i) begin
            state_d    = S_LOAD;
            ch_d       = {CHW{1'b0}};
            err_d      = dp_valid_out_i;
            busy_d     = 1'b1;
            dp_start_d = 1'b1;
            load_go_s  = 1'b1;
            load_ch_s  = {CHW{1'b0}};
            in_cnt_d   = {CW{1'b0}};
            out_cnt_d  = {CW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: begin
          if (load_done_s) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_LOAD;
          end
        end
        S_STREAM: begin
          if (xfer_s) begin
            in_cnt_d = in_cnt_q + CW'(1'b1);
            if (in_cnt_q == PIX_LAST) begin
              state_d = S_DRAIN;
            end else begin
              state_d = S_STREAM;
            end
          end else begin
            state_d = S_STREAM;
          end
        end
        S_DRAIN: begin
          if (out_cnt_q == PIX_FULL) begin
            in_cnt_d  = {CW{1'b0}};
            out_cnt_d = {CW{1'b0}};
            if (ch_q == CH_LAST) begin
              state_d = S_FIN;
              done_d  = 1'b1;
            end else begin
              state_d   = S_LOAD;
              ch_d      = ch_q + CHW'(1'b1);
              load_ch_s = ch_q + CHW'(1'b1);
              load_go_s = 1'b1;
            end
          end else begin
            state_d = S_DRAIN;
          end
        end
        S_FIN: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered-output update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ch_q         <= {CHW{1'b0}};
      in_cnt_q     <= {CW{1'b0}};
      out_cnt_q    <= {CW{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_feature_q <= {DATA_WIDTH{1'b0}};
      dp_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dp_start_q   <= dp_start_d;
      dp_feature_q <= dp_feature_d;
      dp_valid_q   <= dp_valid_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign ch_idx_o     = ch_q;
  assign in_ready_o   = in_ready_s;
  assign dp_start_o   = dp_start_q;
  assign dp_feature_o = dp_feature_q;
  assign dp_valid_o   = dp_valid_q;

endmodule

// File: tb/tb_bn_channel_scheduler.sv
// Bench for bn_channel_scheduler on a 2x2 map with 2 channels. The ROM returns
// address+1, the datapath stand-in echoes dp_valid four cycles later. Expected
// values come from a simple reference: every accepted input word is queued and
// must reappear on dp_feature in order; the channel of the n-th output is
// n/PIX and its parameters are 4*ch+1..4*ch+4.
module tb_bn_channel_scheduler;

  localparam int H   = 2;
  localparam int W   = 2;
  localparam int CH  = 2;
  localparam int DW  = 16;
  localparam int PIX = H * W;

  logic          clk = 1'b0;
  logic          rst, start, abort, spur;
  logic          busy, done, err, rom_en, in_valid, in_ready;
  logic          dp_start, dp_valid, dp_valid_out;
  logic [0:0]    ch_idx;
  logic [2:0]    rom_addr;
  logic [DW-1:0] rom_data, gamma, beta, mean, variance, in_data, dp_feature;
  logic [3:0]    dl;

  int            errors = 0;
  int            checks = 0;
  int            mode, layer_feat, done_cnt, rom_cnt, pushed;
  bit            xfer_prev;
  logic [DW-1:0] cur_word;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  bn_channel_scheduler #(
    .IMG_HEIGHT(H), .IMG_WIDTH(W), .CHANNELS(CH), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .busy_o(busy), .done_o(done), .err_o(err), .ch_idx_o(ch_idx),
    .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .gamma_o(gamma), .beta_o(beta), .mean_o(mean), .variance_o(variance),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .dp_start_o(dp_start), .dp_feature_o(dp_feature), .dp_valid_o(dp_valid),
    .dp_valid_out_i(dp_valid_out)
  );

  // ROM stand-in: word = address + 1, one cycle latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= 16'(rom_addr) + 16'd1;
  end

  // Datapath stand-in: output strobe four cycles after each input strobe
  always @(posedge clk) begin
    if (rst) dl <= 4'b0;
    else     dl <= {dl[2:0], dp_valid};
  end
  assign dp_valid_out = dl[3] | spur;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: observe outputs at the falling edge, then drive this cycle's inputs
  task automatic tick(input bit st = 1'b0, input bit ab = 1'b0, input bit sp = 1'b0);
    int            exp_ch;
    logic [DW-1:0] exp_f;
    @(negedge clk);
    if (dp_valid) begin
      exp_ch = layer_feat / PIX;
      check_eq("feat_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_f = exp_q.pop_front();
        check_eq("dp_feature", dp_feature, exp_f);
      end
      check_eq("ch_idx", ch_idx, exp_ch);
      check_eq("gamma", gamma, exp_ch * 4 + 1);
      check_eq("beta", beta, exp_ch * 4 + 2);
      check_eq("mean", mean, exp_ch * 4 + 3);
      check_eq("variance", variance, exp_ch * 4 + 4);
      layer_feat++;
    end
    if (done) begin
      done_cnt++;
      check_eq("feat_at_done", layer_feat, PIX * CH);
    end
    if (rom_en) rom_cnt++;
    if (xfer_prev) cur_word = 16'($urandom_range(0, 65535));
    case (mode)
      0:       in_valid = 1'b0;
      1:       in_valid = 1'b1;
      2:       in_valid = ~in_valid;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_data = cur_word;
    start   = st;
    abort   = ab;
    spur    = sp;
    #1;
    xfer_prev = in_valid && in_ready;
    if (xfer_prev) begin
      exp_q.push_back(cur_word);
      pushed++;
    end
  endtask

  task automatic layer_init(input int md);
    layer_feat = 0;
    done_cnt   = 0;
    rom_cnt    = 0;
    pushed     = 0;
    exp_q.delete();
    mode = md;
  endtask

  task automatic run_layer(input int md, input bit spur_load, input bit start_mid);
    int budget;
    layer_init(md);
    tick(1'b1);
    tick();
    check_eq("busy_on_start", busy, 1);
    check_eq("dp_start_on", dp_start, 1);
    check_eq("err_cleared", err, 0);
    check_eq("ch0_first", ch_idx, 0);
    check_eq("rom_en_first", rom_en, 1);
    tick(1'b0, 1'b0, spur_load);
    check_eq("dp_start_pulse", dp_start, 0);
    if (spur_load) begin
      tick();
      check_eq("err_spurious", err, 1);
    end
    if (start_mid) begin
      budget = 0;
      while (pushed < 2 && budget < 100) begin tick(); budget++; end
      tick(1'b1);
      tick();
      check_eq("ch_after_restart", ch_idx, 0);
      check_eq("busy_after_restart", busy, 1);
      check_eq("dp_start_restart", dp_start, 0);
    end
    budget = 0;
    while (done_cnt == 0 && budget < 400) begin tick(); budget++; end
    check_eq("done_seen", done_cnt, 1);
    tick();
    check_eq("busy_after_done", busy, 0);
    check_eq("done_pulse", done, 0);
    repeat (8) tick();
    check_eq("done_once", done_cnt, 1);
    check_eq("rom_reads", rom_cnt, 4 * CH);
    check_eq("feat_count", layer_feat, PIX * CH);
    check_eq("accepted", pushed, PIX * CH);
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("err_end", err, 32'(spur_load));
    check_eq("gamma_held", gamma, (CH - 1) * 4 + 1);
    check_eq("var_held", variance, (CH - 1) * 4 + 4);
  endtask

  initial begin
    int budget;
    rst = 1'b1; start = 1'b0; abort = 1'b0; spur = 1'b0;
    in_valid = 1'b0; in_data = 16'd0; mode = 0; xfer_prev = 1'b0;
    layer_feat = 0; done_cnt = 0; rom_cnt = 0; pushed = 0;
    cur_word = 16'($urandom_range(0, 65535));
    repeat (3) tick();
    check_eq("rst_ctrl", {busy, done, err, in_ready, rom_en, dp_start, dp_valid, ch_idx, rom_addr}, 0);
    check_eq("rst_gb", {gamma, beta}, 0);
    check_eq("rst_mv", {mean, variance}, 0);
    check_eq("rst_feat", dp_feature, 0);
    rst = 1'b0;

    run_layer(1, 1'b0, 1'b0);   // in_valid always high
    run_layer(2, 1'b0, 1'b0);   // in_valid toggling
    run_layer(3, 1'b0, 1'b0);   // random in_valid

    // Abort in the last channel's drain phase
    layer_init(1);
    tick(1'b1);
    budget = 0;
    while (pushed < PIX * CH && budget < 200) begin tick(); budget++; end
    check_eq("abort_reached_drain", pushed, PIX * CH);
    check_eq("abort_in_ch1", ch_idx, 1);
    tick(1'b0, 1'b1);
    tick();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_ready", in_ready, 0);
    check_eq("abort_rom", rom_en, 0);
    repeat (8) tick();
    check_eq("abort_no_done", done_cnt, 0);
    check_eq("abort_late_err", err, 1);

    // Start and abort together in IDLE: stay idle
    tick(1'b1, 1'b1);
    tick();
    check_eq("start_abort_busy", busy, 0);
    check_eq("start_abort_dps", dp_start, 0);
    check_eq("start_abort_rom", rom_en, 0);

    run_layer(1, 1'b0, 1'b0);   // rerun from channel 0 after abort
    run_layer(1, 1'b1, 1'b0);   // spurious datapath strobe in LOAD
    run_layer(1, 1'b0, 1'b1);   // start pulsed mid-stream

    // Reset held three cycles in the middle of streaming
    layer_init(1);
    tick(1'b1);
    budget = 0;
    while (pushed < 2 && budget < 100) begin tick(); budget++; end
    mode = 0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("mid_rst_ctrl", {busy, done, err, in_ready, rom_en, dp_start, dp_valid, ch_idx, rom_addr}, 0);
    check_eq("mid_rst_gb", {gamma, beta}, 0);
    check_eq("mid_rst_mv", {mean, variance}, 0);
    check_eq("mid_rst_feat", dp_feature, 0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_busy", busy, 0);
    check_eq("post_rst_ready", in_ready, 0);
    run_layer(2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
